// File: rtl/mem_arbiter_if.sv
// Request/response and memory-side bundle for mem_arbiter.
// The arbiter connects through the slave modport; the core/memory side uses master.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int MEM_AW = 10
);
  logic              if_req_valid;
  logic [ADDR_W-1:0] if_req_addr;
  logic              if_req_ready;
  logic              if_rsp_valid;
  logic [31:0]       if_rsp_rdata;

  logic              d_req_valid;
  logic              d_req_we;
  logic [3:0]        d_req_be;
  logic [ADDR_W-1:0] d_req_addr;
  logic [31:0]       d_req_wdata;
  logic              d_req_ready;
  logic              d_rsp_valid;
  logic [31:0]       d_rsp_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [3:0]        mem_be;
  logic [MEM_AW-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport slave (
    input  if_req_valid, if_req_addr,
    input  d_req_valid, d_req_we, d_req_be, d_req_addr, d_req_wdata,
    input  mem_rdata,
    output if_req_ready, if_rsp_valid, if_rsp_rdata,
    output d_req_ready, d_rsp_valid, d_rsp_rdata,
    output mem_en, mem_we, mem_be, mem_addr, mem_wdata
  );

  modport master (
    output if_req_valid, if_req_addr,
    output d_req_valid, d_req_we, d_req_be, d_req_addr, d_req_wdata,
    output mem_rdata,
    input  if_req_ready, if_rsp_valid, if_rsp_rdata,
    input  d_req_ready, d_rsp_valid, d_rsp_rdata,
    input  mem_en, mem_we, mem_be, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter for a single-port 1-cycle-latency memory; data wins unless fetch is starved.
// Optional performance counters are enabled by defining MEM_ARB_PERF_EN.
module mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int MEM_AW       = 10,
  parameter int STARVE_LIMIT = 4
) (
  input  logic         clk,
  input  logic         reset,
  mem_arbiter_if.slave bus
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0]  perf_if_grants,
  output logic [31:0]  perf_d_grants,
  output logic [31:0]  perf_conflicts
`endif
);

  localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_IF,
    OWN_D_RD,
    OWN_D_WR
  } owner_e;

  owner_e           rspOwner_q, rspOwner_d;
  logic [CNT_W-1:0] starveCnt_q, starveCnt_d;
  logic             fetchPri;
  logic             ifGrant;
  logic             dGrant;
  logic             unusedAddrBits;

  assign unusedAddrBits = ^{bus.if_req_addr[ADDR_W-1:MEM_AW+2], bus.if_req_addr[1:0],
                            bus.d_req_addr[ADDR_W-1:MEM_AW+2], bus.d_req_addr[1:0]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rspOwner_q  <= OWN_NONE;
      starveCnt_q <= '0;
    end else begin
      rspOwner_q  <= rspOwner_d;
      starveCnt_q <= starveCnt_d;
    end
  end

  // Grants are gated by reset so every output drops the moment reset asserts.
  always_comb begin
    fetchPri         = (starveCnt_q == CNT_MAX);
    ifGrant          = 1'b0;
    dGrant           = 1'b0;
    rspOwner_d       = OWN_NONE;
    starveCnt_d      = '0;
    bus.mem_en       = 1'b0;
    bus.mem_we       = 1'b0;
    bus.mem_be       = 4'h0;
    bus.mem_addr     = '0;
    bus.mem_wdata    = '0;
    bus.if_rsp_valid = 1'b0;
    bus.if_rsp_rdata = '0;
    bus.d_rsp_valid  = 1'b0;
    bus.d_rsp_rdata  = '0;

    if (reset) begin
      if (bus.if_req_valid && (fetchPri || !bus.d_req_valid)) begin
        ifGrant = 1'b1;
      end else if (bus.d_req_valid) begin
        dGrant = 1'b1;
      end
      bus.mem_wdata = bus.d_req_wdata;
    end

    if (ifGrant) begin
      rspOwner_d   = OWN_IF;
      bus.mem_en   = 1'b1;
      bus.mem_be   = 4'hF;
      bus.mem_addr = bus.if_req_addr[MEM_AW+1:2];
    end else if (dGrant) begin
      rspOwner_d   = bus.d_req_we ? OWN_D_WR : OWN_D_RD;
      bus.mem_en   = 1'b1;
      bus.mem_we   = bus.d_req_we;
      bus.mem_be   = bus.d_req_we ? bus.d_req_be : 4'hF;
      bus.mem_addr = bus.d_req_addr[MEM_AW+1:2];
    end

    if (bus.if_req_valid && !ifGrant) begin
      starveCnt_d = fetchPri ? CNT_MAX : starveCnt_q + CNT_W'(1);
    end

    // Store acknowledges carry zero data; the memory read bus is stale for them.
    case (rspOwner_q)
      OWN_IF: begin
        bus.if_rsp_valid = 1'b1;
        bus.if_rsp_rdata = bus.mem_rdata;
      end
      OWN_D_RD: begin
        bus.d_rsp_valid = 1'b1;
        bus.d_rsp_rdata = bus.mem_rdata;
      end
      OWN_D_WR: begin
        bus.d_rsp_valid = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.if_req_ready = ifGrant;
  assign bus.d_req_ready  = dGrant;

`ifdef MEM_ARB_PERF_EN
  logic [31:0] perfIf_q, perfD_q, perfConf_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perfIf_q   <= '0;
      perfD_q    <= '0;
      perfConf_q <= '0;
    end else begin
      if (ifGrant) perfIf_q <= perfIf_q + 32'd1;
      if (dGrant) perfD_q <= perfD_q + 32'd1;
      if (bus.if_req_valid && bus.d_req_valid) perfConf_q <= perfConf_q + 32'd1;
    end
  end

  assign perf_if_grants = perfIf_q;
  assign perf_d_grants  = perfD_q;
  assign perf_conflicts = perfConf_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scoreboard bench for mem_arbiter: grants and mem_* checked combinationally,
// expected responses queued per cycle and compared one edge later.
module tb_mem_arbiter;

  typedef struct packed {
    logic        ifV;
    logic        dV;
    logic [31:0] ifD;
    logic [31:0] dD;
  } exp_t;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  exp_t scoreQ[$];

  mem_arbiter_if #(.ADDR_W(32), .MEM_AW(10)) bus ();

`ifdef MEM_ARB_PERF_EN
  logic [31:0] perfIf, perfD, perfConf;
`endif

  mem_arbiter #(.ADDR_W(32), .MEM_AW(10), .STARVE_LIMIT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef MEM_ARB_PERF_EN
    ,
    .perf_if_grants (perfIf),
    .perf_d_grants  (perfD),
    .perf_conflicts (perfConf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic ifV, input logic [31:0] ifA,
                               input logic dV, input logic dWe, input logic [3:0] dBe,
                               input logic [31:0] dA, input logic [31:0] dWd,
                               input logic [31:0] rdNext,
                               input logic expIf, input logic expD);
    exp_t e;
    exp_t got;
    logic [3:0] beExp;
    bus.if_req_valid = ifV;
    bus.if_req_addr  = ifA;
    bus.d_req_valid  = dV;
    bus.d_req_we     = dWe;
    bus.d_req_be     = dBe;
    bus.d_req_addr   = dA;
    bus.d_req_wdata  = dWd;
    #1;
    checkOutput("if_req_ready", {31'b0, bus.if_req_ready}, {31'b0, expIf});
    checkOutput("d_req_ready", {31'b0, bus.d_req_ready}, {31'b0, expD});
    checkOutput("mem_en", {31'b0, bus.mem_en}, {31'b0, expIf | expD});
    checkOutput("mem_we", {31'b0, bus.mem_we}, {31'b0, expD & dWe});
    beExp = expIf ? 4'hF : (expD ? (dWe ? dBe : 4'hF) : 4'h0);
    checkOutput("mem_be", {28'b0, bus.mem_be}, {28'b0, beExp});
    if (expIf) checkOutput("mem_addr_if", {22'b0, bus.mem_addr}, {22'b0, ifA[11:2]});
    else if (expD) checkOutput("mem_addr_d", {22'b0, bus.mem_addr}, {22'b0, dA[11:2]});
    if (expD && dWe) checkOutput("mem_wdata", bus.mem_wdata, dWd);
    e.ifV = expIf;
    e.dV  = expD;
    e.ifD = expIf ? rdNext : 32'h0;
    e.dD  = (expD && !dWe) ? rdNext : 32'h0;
    scoreQ.push_back(e);
    @(posedge clk);
    #1;
    bus.mem_rdata = rdNext;
    #1;
    if (scoreQ.size() == 0) begin
      total++;
      bad++;
      $error("[TB] FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      got = scoreQ.pop_front();
      checkOutput("if_rsp_valid", {31'b0, bus.if_rsp_valid}, {31'b0, got.ifV});
      checkOutput("d_rsp_valid", {31'b0, bus.d_rsp_valid}, {31'b0, got.dV});
      checkOutput("if_rsp_rdata", bus.if_rsp_rdata, got.ifD);
      checkOutput("d_rsp_rdata", bus.d_rsp_rdata, got.dD);
    end
    @(negedge clk);
  endtask

  task automatic idleStep(input logic [31:0] rdNext);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, rdNext, 1'b0, 1'b0);
  endtask

  initial begin
    #20000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b0;
    bus.if_req_valid = 1'b1;
    bus.if_req_addr  = 32'h0000_0024;
    bus.d_req_valid  = 1'b1;
    bus.d_req_we     = 1'b1;
    bus.d_req_be     = 4'hF;
    bus.d_req_addr   = 32'h0000_0048;
    bus.d_req_wdata  = 32'hCAFE_F00D;
    bus.mem_rdata    = 32'hA5A5_A5A5;

    // Reset held with both requesters active: everything must be zero.
    @(posedge clk);
    #1;
    checkOutput("rst_if_ready", {31'b0, bus.if_req_ready}, 32'h0);
    checkOutput("rst_d_ready", {31'b0, bus.d_req_ready}, 32'h0);
    checkOutput("rst_if_rsp_valid", {31'b0, bus.if_rsp_valid}, 32'h0);
    checkOutput("rst_d_rsp_valid", {31'b0, bus.d_rsp_valid}, 32'h0);
    checkOutput("rst_if_rdata", bus.if_rsp_rdata, 32'h0);
    checkOutput("rst_d_rdata", bus.d_rsp_rdata, 32'h0);
    checkOutput("rst_mem_en", {31'b0, bus.mem_en}, 32'h0);
    checkOutput("rst_mem_we", {31'b0, bus.mem_we}, 32'h0);
    checkOutput("rst_mem_be", {28'b0, bus.mem_be}, 32'h0);
    checkOutput("rst_mem_addr", {22'b0, bus.mem_addr}, 32'h0);
    checkOutput("rst_mem_wdata", bus.mem_wdata, 32'h0);
    @(negedge clk);
    reset = 1'b1;

    // First cycle after release: data has default priority.
    applyStimulus(1'b1, 32'h40, 1'b1, 1'b0, 4'h0, 32'h44, 32'h0, 32'h1111_1111, 1'b0, 1'b1);
    idleStep(32'h2222_2222);

    // Lone fetch.
    applyStimulus(1'b1, 32'h10, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'hDEAD_BEEF, 1'b1, 1'b0);

    // Contention, then data drops and fetch follows in the next cycle.
    applyStimulus(1'b1, 32'h30, 1'b1, 1'b0, 4'h0, 32'h20, 32'h0, 32'h3333_3333, 1'b0, 1'b1);
    applyStimulus(1'b1, 32'h30, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h4444_4444, 1'b1, 1'b0);
    idleStep(32'h5555_5555);

    // Starvation: four denials, fetch on the fifth, data again on the sixth.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 32'h50, 1'b1, 1'b0, 4'h0, 32'h60 + 32'(4 * i), 32'h0,
                    32'h5000_0000 + 32'(i), 1'b0, 1'b1);
    end
    applyStimulus(1'b1, 32'h50, 1'b1, 1'b0, 4'h0, 32'h70, 32'h0, 32'h6666_6666, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'h54, 1'b1, 1'b0, 4'h0, 32'h70, 32'h0, 32'h7777_7777, 1'b0, 1'b1);
    idleStep(32'h0BAD_0BAD);

    // Store with partial byte enables acknowledges with zero data.
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 4'b0011, 32'h8, 32'h1234, 32'h8888_8888, 1'b0, 1'b1);
    idleStep(32'h9999_9999);

    // Fetch accepted, then reset asserted before the edge: no response may appear.
    bus.if_req_valid = 1'b1;
    bus.if_req_addr  = 32'h14;
    bus.d_req_valid  = 1'b0;
    #1;
    checkOutput("mid_if_ready", {31'b0, bus.if_req_ready}, 32'h1);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("mid_rst_if_ready", {31'b0, bus.if_req_ready}, 32'h0);
    checkOutput("mid_rst_mem_en", {31'b0, bus.mem_en}, 32'h0);
    @(posedge clk);
    #1;
    bus.mem_rdata = 32'hFEED_FACE;
    #1;
    checkOutput("mid_rst_if_rsp", {31'b0, bus.if_rsp_valid}, 32'h0);
    checkOutput("mid_rst_if_rdata", bus.if_rsp_rdata, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    idleStep(32'hFEED_FACE);

`ifdef MEM_ARB_PERF_EN
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 32'h80, 1'b1, 1'b0, 4'h0, 32'h90 + 32'(4 * i), 32'h0,
                    32'hC000_0000 + 32'(i), 1'b0, 1'b1);
    end
    checkOutput("perf_conflicts", perfConf, 32'd3);
    checkOutput("perf_grant_sum", perfIf + perfD, 32'd3);
    checkOutput("perf_d_grants", perfD, 32'd3);
    idleStep(32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-port synchronous unified memory between the core's instruction-fetch port and its load/store data port.
- Default priority: data first.
- A starvation counter guarantees fetch forward progress.
- Sits between the core pipeline and the memory inside the top level. Issues at most one memory access per cycle and routes the one-cycle-latency read data back to the owning requester.

Parameters:
- ADDR_W, 32, byte-address width of both request ports.
- MEM_AW, 10, word-address width of the memory; mem_addr = req_addr[MEM_AW+1:2].
- STARVE_LIMIT, 4, consecutive denied fetch cycles before fetch takes priority; legal range is 1 or more.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- if_req_valid  in  1  fetch request.
- if_req_addr  in  ADDR_W  fetch byte address.
- if_req_ready  out  1  fetch accepted this cycle.
- if_rsp_valid  out  1  fetch data valid.
- if_rsp_rdata  out  32  fetch data.
- d_req_valid  in  1  data request.
- d_req_we  in  1  1 = store.
- d_req_be  in  4  store byte enables.
- d_req_addr  in  ADDR_W  data byte address.
- d_req_wdata  in  32  store data.
- d_req_ready  out  1  data accepted this cycle.
- d_rsp_valid  out  1  load data valid or store acknowledge.
- d_rsp_rdata  out  32  load data; 0 for stores.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write.
- mem_be  out  4  memory byte enables.
- mem_addr  out  MEM_AW  memory word address.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data, valid the cycle after a read with mem_en=1.

Behaviour:
- Grant (combinational from registered state):
  - Fetch priority is active when starve_cnt == STARVE_LIMIT.
  - Fetch priority active and if_req_valid: fetch wins.
  - Otherwise d_req_valid: data wins.
  - Otherwise if_req_valid: fetch wins.
  - Exactly one of if_req_ready / d_req_ready is high, and only when its valid is high. Both are 0 when no request is pending.
- Accept = valid & ready. On accept, mem_* are driven the same cycle:
  - mem_en = 1.
  - mem_we = d_req_we for data, 0 for fetch.
  - mem_be = d_req_be for data stores, 4'b1111 for fetch and loads.
  - mem_wdata = d_req_wdata.
  - With no accept: mem_en = 0, mem_we = 0, mem_be = 0.
- Response owner register rsp_owner, states NONE / IF / D_RD / D_WR:
  - Loaded every cycle from the current accept; NONE if no accept.
  - Next cycle: IF gives if_rsp_valid=1 with if_rsp_rdata=mem_rdata.
  - D_RD gives d_rsp_valid=1 with d_rsp_rdata=mem_rdata.
  - D_WR gives d_rsp_valid=1 with d_rsp_rdata=0.
  - Non-owner rsp_rdata is 0.
- Latency: exactly 1 cycle from accept to rsp_valid. Fully pipelined, so back-to-back accepts produce back-to-back responses. Responses have no backpressure.
- starve_cnt, width $clog2(STARVE_LIMIT+1):
  - Increments (saturating at STARVE_LIMIT) on cycles with if_req_valid & !if_req_ready.
  - Clears on fetch accept or when if_req_valid = 0.
- Requesters hold valid and payload stable until accepted. The arbiter does not check this.
- Reset asserted (reset = 0), effective immediately:
  - rsp_owner = NONE and starve_cnt = 0.
  - All outputs 0, including ready, rsp_valid, rdata and mem_*.
  - An access accepted in the cycle before reset produces no response.
- After reset deasserts, arbitration resumes on the first rising edge.

Optional Feature:
- Macro MEM_ARB_PERF_EN, when defined:
  - Adds outputs perf_if_grants[31:0], perf_d_grants[31:0] and perf_conflicts[31:0].
  - perf_if_grants and perf_d_grants count accepts per port.
  - perf_conflicts counts cycles where both valids are high.
  - All counters wrap modulo 2^32 and reset to 0.
- When undefined: these ports and their registers do not exist, and all other behaviour is identical.

Test Plan:
- Reset: hold reset=0 with both valids=1 -> every output is 0; after release, first rising edge grants data.
- Lone fetch: if_req_valid=1, addr=0x10, mem_rdata=0xDEADBEEF next cycle -> if_req_ready=1, mem_addr=4, mem_en=1, mem_we=0; next cycle if_rsp_valid=1 with rdata=0xDEADBEEF and d_rsp_valid=0.
- Contention: both valid, data load at 0x20 -> d_req_ready=1, if_req_ready=0, mem_addr=8. Drop d_req_valid next cycle -> fetch granted; d_rsp_valid and if_rsp_valid pulse in consecutive cycles.
- Starvation: d_req_valid held 1 and if_req_valid held 1, STARVE_LIMIT=4 -> fetch denied 4 cycles, granted on cycle 5, then data granted on cycle 6 (counter cleared).
- Store: d_req_we=1, be=4'b0011, addr=0x8, wdata=0x1234 -> mem_we=1, mem_be=0011, mem_addr=2, mem_wdata=0x1234; next cycle d_rsp_valid=1 with rdata=0.
- Reset mid-flight and perf: accept a fetch, assert reset before the next edge -> no if_rsp_valid ever appears. With MEM_ARB_PERF_EN, 3 contended cycles -> perf_conflicts=3 and grant counters sum to 3.
